// File: rtl/clock_divider_multi.sv
// clock_divider_multi: CHANNELS independent run-time programmable clock dividers.
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   en       per-channel run enable
//   sync     synchronous restart of every channel, applies all pending configs
//   cfg_*    write strobe, target channel, divisor and mode (0 toggle, 1 pulse)
//   clk_out  divided output per channel
//   tick     one-cycle strobe at each terminal count
//   pending  shadow config written but not yet applied
module clock_divider_multi #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 26,
    parameter int SELW       = 2,
    parameter int RESET_DIV  = 49_999_999,
    parameter bit RESET_MODE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [SELW-1:0]     cfg_sel,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt, adiv, sdiv;
        logic amode, smode, upd, co, tk, pd;
        logic wr, tc;
        assign wr = cfg_we && (cfg_sel == SELW'(g));
        assign tc = cnt == adiv;
        assign clk_out[g] = co;
        assign tick[g] = tk;
        assign pending[g] = pd;
        // Shadow always equals active unless pd or upd is set, so copying
        // shadow into active at every apply point is harmless. upd marks a
        // write to a disabled channel, applied on the following edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                adiv  <= WIDTH'(RESET_DIV);
                sdiv  <= WIDTH'(RESET_DIV);
                amode <= RESET_MODE;
                smode <= RESET_MODE;
                upd   <= 1'b0;
                co    <= 1'b0;
                tk    <= 1'b0;
                pd    <= 1'b0;
            end else begin
                if (wr) begin
                    sdiv  <= cfg_div;
                    smode <= cfg_mode;
                end
                if (sync || upd) begin
                    cnt   <= '0;
                    tk    <= 1'b0;
                    co    <= !sync && !amode && !smode && co;
                    adiv  <= sdiv;
                    amode <= smode;
                    pd    <= wr && en[g];
                    upd   <= wr && !en[g];
                end else if (!en[g]) begin
                    tk  <= 1'b0;
                    co  <= co && !amode;
                    upd <= wr;
                end else if (tc) begin
                    cnt   <= '0;
                    tk    <= 1'b1;
                    co    <= (amode != smode) ? 1'b0 : (amode || !co);
                    adiv  <= sdiv;
                    amode <= smode;
                    pd    <= wr;
                end else begin
                    cnt <= cnt + WIDTH'(1);
                    tk  <= 1'b0;
                    co  <= co && !amode;
                    pd  <= pd || wr;
                end
            end
        end
    end
endmodule
